// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: block fill and write-forward controller, cache <-> memory.
// Optional CACHE_FILL_STATS_EN adds a saturating fill_count output.
module cache_fill_ctrl #(
  parameter int MEM_LAT    = 4,
  parameter int WORDS      = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_miss,
  input  logic                  cache_wr,
  input  logic [ADDR_WIDTH-1:0] cache_addr,
  input  logic [15:0]           cache_wdata,
  output logic                  data_valid,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [15:0]           fill_data,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata
`ifdef CACHE_FILL_STATS_EN
  ,
  output logic [15:0]           fill_count
`endif
);

  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFS   = $clog2(WORDS) + 1;
  localparam int DEPTH = MEM_LAT + 1;

  localparam logic [ADDR_WIDTH-1:0] OFS_MASK =
    ADDR_WIDTH'((1 << OFS) - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    COOL
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [IW-1:0]         rd_idx;
  logic [IW-1:0]         beat_cnt;
  logic                  wr_pend;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           wr_data;
  logic [15:0]           rdata_q;
  logic [DEPTH-1:0]      pipe_v;
  logic [ADDR_WIDTH-1:0] pipe_a [DEPTH];

  logic                  start_fill;
  logic                  wr_accept;
  logic                  last_rd;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] blk_base;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign blk_base  = cache_addr & ~OFS_MASK;
  assign rd_addr   = base_q + ADDR_WIDTH'({rd_idx, 1'b0});
  assign last_rd   = (rd_idx == LAST_IDX);
  assign last_beat = data_valid && (beat_cnt == LAST_IDX);

  always_comb begin
    state_nx   = state;
    start_fill = 1'b0;
    wr_accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cache_miss) begin
          state_nx   = FILL;
          start_fill = 1'b1;
        end else begin
          wr_accept = cache_wr;
        end
      end
      FILL: begin
        if (last_rd) state_nx = DRAIN;
      end
      DRAIN: begin
        if (last_beat) state_nx = COOL;
      end
      COOL: begin
        // miss still high here is the tail of the last fill
        if (!cache_miss) begin
          state_nx  = IDLE;
          wr_accept = cache_wr;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  assign mem_rd_en = (state == FILL);
  assign mem_wr_en = wr_pend;
  assign mem_addr  = mem_rd_en ? rd_addr : wr_addr;
  assign mem_wdata = wr_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q   <= '0;
      rd_idx   <= '0;
      beat_cnt <= '0;
    end else begin
      if (data_valid) beat_cnt <= beat_cnt + IW'(1);
      if (start_fill) begin
        base_q   <= blk_base;
        rd_idx   <= '0;
        beat_cnt <= '0;
      end else if (mem_rd_en) begin
        rd_idx <= rd_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_pend <= wr_accept;
      if (wr_accept) begin
        wr_addr <= cache_addr;
        wr_data <= cache_wdata;
      end
    end
  end

  // read data lands MEM_LAT cycles after issue; stage MEM_LAT meets rdata_q
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      pipe_v  <= '0;
      for (int i = 0; i < DEPTH; i++) pipe_a[i] <= '0;
    end else begin
      rdata_q   <= mem_rdata;
      pipe_v    <= {pipe_v[DEPTH-2:0], mem_rd_en};
      pipe_a[0] <= mem_addr;
      for (int i = 1; i < DEPTH; i++) pipe_a[i] <= pipe_a[i-1];
    end
  end

  assign data_valid = pipe_v[DEPTH-1];
  assign fill_addr  = data_valid ? pipe_a[DEPTH-1] : '0;
  assign fill_data  = data_valid ? rdata_q : '0;

`ifdef CACHE_FILL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_count <= '0;
    end else if (start_fill && fill_count != 16'hFFFF) begin
      fill_count <= fill_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: scoreboard bench for cache_fill_ctrl.
// Memory model returns a fixed function of the address after LAT cycles.
module tb_cache_fill_ctrl;

  localparam int LAT   = 4;
  localparam int WORDS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cache_miss;
  logic        cache_wr;
  logic [15:0] cache_addr;
  logic [15:0] cache_wdata;
  logic        data_valid;
  logic [15:0] fill_addr;
  logic [15:0] fill_data;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
`ifdef CACHE_FILL_STATS_EN
  logic [15:0] fill_count;
`endif

  cache_fill_ctrl #(
    .MEM_LAT   (LAT),
    .WORDS     (WORDS),
    .ADDR_WIDTH(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cache_miss (cache_miss),
    .cache_wr   (cache_wr),
    .cache_addr (cache_addr),
    .cache_wdata(cache_wdata),
    .data_valid (data_valid),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef CACHE_FILL_STATS_EN
    ,
    .fill_count (fill_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mdat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  logic [LAT-1:0] h_v = '0;
  logic [15:0]    h_a [LAT];

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      h_v[i] <= h_v[i-1];
      h_a[i] <= h_a[i-1];
    end
    h_v[0] <= mem_rd_en;
    h_a[0] <= mem_addr;
  end

  assign mem_rdata = h_v[LAT-1] ? mdat(h_a[LAT-1]) : 16'h0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_fills = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %h expected none", nm, act);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    int          c;
  } ev_t;

  ev_t fq[$];
  ev_t rq[$];
  ev_t wq[$];

  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst) begin
      if (mem_rd_en && mem_wr_en) bad("rd_wr_overlap", 32'(cyc));
      if (data_valid) begin
        if (fq.size() == 0) begin
          bad("extra_beat", 32'(fill_addr));
        end else begin
          e = fq.pop_front();
          chk("beat_addr", 32'(fill_addr), 32'(e.a));
          chk("beat_data", 32'(fill_data), 32'(e.d));
          chk("beat_cyc", 32'(cyc), 32'(e.c));
        end
      end
      if (mem_rd_en) begin
        if (rq.size() == 0) begin
          bad("extra_read", 32'(mem_addr));
        end else begin
          e = rq.pop_front();
          chk("rd_addr", 32'(mem_addr), 32'(e.a));
          chk("rd_cyc", 32'(cyc), 32'(e.c));
        end
      end
      if (mem_wr_en) begin
        if (wq.size() == 0) begin
          bad("extra_write", 32'(mem_addr));
        end else begin
          e = wq.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e.a));
          chk("wr_data", 32'(mem_wdata), 32'(e.d));
          chk("wr_cyc", 32'(cyc), 32'(e.c));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fill(input logic [15:0] a, input int t);
    ev_t         e;
    logic [15:0] b;
    b = {a[15:4], 4'h0};
    for (int k = 0; k < WORDS; k++) begin
      e.a = b + 16'(2 * k);
      e.d = 16'h0;
      e.c = t + 1 + k;
      rq.push_back(e);
      e.d = mdat(e.a);
      e.c = t + k + LAT + 2;
      fq.push_back(e);
    end
    n_fills++;
  endtask

  task automatic do_fill(input logic [15:0] a, input int hold,
                         input logic with_wr);
    cache_miss  = 1'b1;
    cache_addr  = a;
    cache_wr    = with_wr;
    cache_wdata = 16'hDEAD;
    push_fill(a, cyc);
    step();
    cache_wr = 1'b0;
    repeat (WORDS + LAT + 1 + hold) step();
    cache_miss = 1'b0;
    step();
  endtask

  task automatic do_wr(input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    cache_wr    = 1'b1;
    cache_addr  = a;
    cache_wdata = d;
    e.a = a;
    e.d = d;
    e.c = cyc + 1;
    wq.push_back(e);
    step();
    cache_wr = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dv"}, 32'(data_valid), 32'h0);
    chk({tag, "_rd"}, 32'(mem_rd_en), 32'h0);
    chk({tag, "_wr"}, 32'(mem_wr_en), 32'h0);
    chk({tag, "_faddr"}, 32'(fill_addr), 32'h0);
    chk({tag, "_fdata"}, 32'(fill_data), 32'h0);
    chk({tag, "_maddr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mwdata"}, 32'(mem_wdata), 32'h0);
  endtask

  initial begin
    int t;
    cache_miss  = 1'b0;
    cache_wr    = 1'b0;
    cache_addr  = 16'h0;
    cache_wdata = 16'h0;
    repeat (2) step();
    chk_zero("reset");
    rst = 1'b1;
    repeat (2) step();

    do_fill(16'h1234, 3, 1'b0);
    do_fill(16'h2468, 0, 1'b0);

    do_wr(16'h0040, 16'hBEEF);
    step();
    do_wr(16'h0102, 16'h1111);
    do_wr(16'h0104, 16'h2222);
    do_wr(16'h0106, 16'h3333);
    repeat (2) step();

    do_fill(16'h5550, 0, 1'b1);
    do_fill(16'hFFF7, 0, 1'b0);
    repeat (2) step();
`ifdef CACHE_FILL_STATS_EN
    chk("fill_count_pre", 32'(fill_count), 32'(n_fills));
`endif

    t           = cyc;
    cache_miss  = 1'b1;
    cache_addr  = 16'h0A00;
    push_fill(16'h0A00, t);
    while (cyc < t + 3 + LAT + 2) step();
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    fq.delete();
    rq.delete();
    wq.delete();
    n_fills    = 0;
    cache_miss = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    repeat (20) step();

    do_fill(16'h0100, 0, 1'b0);
    repeat (5) step();

    chk("beats_left", 32'(fq.size()), 32'h0);
    chk("reads_left", 32'(rq.size()), 32'h0);
    chk("writes_left", 32'(wq.size()), 32'h0);
`ifdef CACHE_FILL_STATS_EN
    chk("fill_count", 32'(fill_count), 32'(n_fills));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Memory-side fill and write-forward controller between the data cache and the pipelined main-memory port. Consumes the cache's miss/write requests (miss, write, block address, write data) and returns the eight-word block fill to it as a stream of data-valid/address/data beats. Issues pipelined reads with fixed latency and forwards write-through stores one word per cycle.

## Interface
- MEM_LAT, 4, main-memory read latency in cycles (legal range 1..8)
- WORDS, 8, 16-bit words per cache block
- ADDR_WIDTH, 16, byte-address width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- cache_miss  in  1  cache requests a block fill
- cache_wr  in  1  cache requests a memory write
- cache_addr  in  16  block base (offset bits [3:0]=0) during miss; word address during write
- cache_wdata  in  16  write data from cache
- data_valid  out  1  fill beat valid to cache
- fill_addr  out  16  byte address of current fill beat
- fill_data  out  16  data of current fill beat
- mem_rd_en  out  1  memory read request
- mem_wr_en  out  1  memory write request
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid MEM_LAT cycles after its request

## Operation
- States: IDLE, FILL, DRAIN, COOL.
- IDLE: cache_miss=1 → latch base = {cache_addr[15:4],4'b0}, go FILL; miss beats write in the same cycle.
- IDLE/COOL with cache_miss=0 and cache_wr=1: register write; next cycle mem_wr_en=1, mem_addr=cache_addr, mem_wdata=cache_wdata. Writes are never accepted while cache_miss=1 or in FILL/DRAIN.
- FILL: one read per cycle, mem_rd_en=1, mem_addr=base+2*i, i=0..WORDS-1 (16-bit add, wraps mod 2^16). After i=WORDS-1 go DRAIN.
- Return tracking: MEM_LAT+1-deep valid/address shift pipeline; each issued read enters with its address; at exit, data_valid=1, fill_addr=tracked address, fill_data=registered mem_rdata.
- DRAIN: wait until the WORDS-th beat leaves the pipeline → COOL.
- COOL: wait for cache_miss=0 (cache drops miss after consuming last beat) → IDLE. A miss still high in COOL never restarts a fill.
- Beats are strictly in ascending address order, exactly WORDS per fill, no back-pressure.

## Timing
- Reset: state IDLE; data_valid, mem_rd_en, mem_wr_en = 0; fill_addr, fill_data, mem_addr, mem_wdata = 0; return pipeline cleared.
- Miss sampled in IDLE at cycle t: reads at t+1..t+WORDS; beat k (k=0..WORDS-1) valid at t+k+MEM_LAT+2.
- Default config: first beat t+6, last t+13, COOL from t+14.
- Write accepted at cycle t → mem_wr_en high exactly in cycle t+1, one cycle per write; back-to-back writes sustain one per cycle.
- mem_rd_en and mem_wr_en are never high together.
- Reset asserted mid-fill: outstanding reads discarded, no further data_valid; returning mem_rdata ignored.

## Configuration
- CACHE_FILL_STATS_EN defined: adds output fill_count (16 bits, reset 0), increments on each FILL entry, saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset mid-fill: assert rst=0 at beat 3 of a fill → all outputs 0 immediately, no beats after release, state IDLE.
- Single fill, cache_addr=16'h1234 miss at t → mem reads 0x1230..0x123E at t+1..t+8; data_valid t+6..t+13 with fill_addr 0x1230..0x123E and matching data.
- Miss held through COOL for 3 cycles → no second fill; drop miss then reassert → new fill starts normally.
- Write 16'hBEEF to 0x0040 in IDLE → mem_wr_en=1, mem_addr=0x0040, mem_wdata=0xBEEF next cycle only; write and miss same cycle → fill only, no mem_wr_en.
- Base 0xFFF0 fill → addresses 0xFFF0..0xFFFE, no wrap; MEM_LAT=1 build → first beat t+3.
- CACHE_FILL_STATS_EN: 3 fills → fill_count=3; preload 0xFFFF → stays 0xFFFF.
